// File: rtl/div8_stream_ctrl.sv
// Streaming valid/ready shell around the 8-bit combinational array divider: operand register
// feeding the divider, result FIFO draining it. Optional dbz flag path: DIV8_DBZ_FLAG_EN.
module div8_stream_ctrl #(
   parameter int RES_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [7:0]                   in_dividend,
   input  logic [7:0]                   in_divisor,
   output logic [7:0]                   div_sbc,
   output logic [7:0]                   div_sc,
   input  logic [7:0]                   div_q,
   input  logic [7:0]                   div_r,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [7:0]                   out_q,
   output logic [7:0]                   out_r,
   output logic                         out_dbz,
   output logic [$clog2(RES_DEPTH):0]   occupancy
);

   localparam int PW = $clog2(RES_DEPTH);
   localparam int OW = PW + 1;

   logic          a_valid_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [OW-1:0] occ_r;
   logic [7:0]    mem_q_r [RES_DEPTH];
   logic [7:0]    mem_r_r [RES_DEPTH];
   logic          push_in_s;
   logic          pop_s;
   logic          a_move_s;

   // Handshake decode; a full FIFO still accepts A when its head leaves this cycle
   always_comb begin
      pop_s     = (occ_r != {OW{1'b0}}) & out_ready;
      a_move_s  = a_valid_r & ((occ_r < OW'(RES_DEPTH)) | pop_s);
      in_ready  = ~a_valid_r | a_move_s;
      push_in_s = in_valid & in_ready;
      out_valid = (occ_r != {OW{1'b0}});
      occupancy = occ_r;
   end

   // Operand stage A: holds divider inputs steady until the result is captured
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_r <= 1'b0;
         div_sbc   <= 8'h00;
         div_sc    <= 8'h00;
      end else if (push_in_s) begin
         a_valid_r <= 1'b1;
         div_sbc   <= in_dividend;
         div_sc    <= in_divisor;
      end else if (a_move_s) begin
         a_valid_r <= 1'b0;
      end else begin
         a_valid_r <= a_valid_r;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         occ_r    <= {OW{1'b0}};
      end else begin
         if (a_move_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({a_move_s, pop_s})
            2'b10:   occ_r <= occ_r + OW'(1);
            2'b01:   occ_r <= occ_r - OW'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Result storage, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (a_move_s) begin
         mem_q_r[wr_ptr_r] <= div_q;
         mem_r_r[wr_ptr_r] <= div_r;
      end
   end

`ifdef DIV8_DBZ_FLAG_EN
   logic a_dbz_r;
   logic mem_dbz_r [RES_DEPTH];

   // Divide-by-zero flag follows the operands through A and the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         a_dbz_r <= 1'b0;
      end else if (push_in_s) begin
         a_dbz_r <= (in_divisor == 8'h00);
      end else begin
         a_dbz_r <= a_dbz_r;
      end
      if (a_move_s) begin
         mem_dbz_r[wr_ptr_r] <= a_dbz_r;
      end
   end
`endif

   // Head presentation, forced to zero while empty
   always_comb begin
      out_q   = 8'h00;
      out_r   = 8'h00;
      out_dbz = 1'b0;
      if (out_valid) begin
         out_q = mem_q_r[rd_ptr_r];
         out_r = mem_r_r[rd_ptr_r];
`ifdef DIV8_DBZ_FLAG_EN
         out_dbz = mem_dbz_r[rd_ptr_r];
`else
         out_dbz = 1'b0;
`endif
      end else begin
         out_q   = 8'h00;
         out_r   = 8'h00;
         out_dbz = 1'b0;
      end
   end

endmodule
